seq_cmd_tx: RTL

SEQ_CMD_TX -- requirements
Module: seq_cmd_tx

---
 rtl/seq_cmd_pkg.sv | 24 ++
 rtl/seq_cmd_timeout.sv | 28 ++
 rtl/seq_cmd_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/seq_cmd_pkg.sv
// Shared types and constants for the sequence command transmitter.
// A frame is a fixed 4-bit preamble followed by the 4-bit delay payload, MSB first.
package seq_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PAY,
        WAIT_DONE,
        ACK
    } state_t;

    localparam logic [3:0] PREAMBLE = 4'b1101;
    localparam int         PRE_LEN  = 4;
    localparam int         PAY_LEN  = 4;

    // Positions 0..3 are preamble bits, 4..7 payload bits; both are sent MSB first.
    function automatic logic frame_bit(input logic [2:0] idx, input logic [3:0] payload);
        logic [1:0] pos;
        pos = ~idx[1:0];
        return idx[2] ? payload[pos] : PREAMBLE[pos];
    endfunction

endpackage

// File: rtl/seq_cmd_timeout.sv
// Cycle counter for the WAIT_DONE state.
// expired is high during the TIMEOUT-th enabled cycle after a clear.
module seq_cmd_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            W    = $clog2(TIMEOUT);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Saturates at LAST so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/seq_cmd_tx.sv
// Sends a preamble plus captured delay value serially, then waits for done and
// answers with a one-cycle ack, or gives up with a one-cycle timeout pulse.
module seq_cmd_tx
    import seq_cmd_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] delay,
    input  logic       done,
    output logic       data,
    output logic       ack,
    output logic       busy,
    output logic       timeout
);

    localparam logic [2:0] LAST_PRE = 3'(PRE_LEN - 1);
    localparam logic [2:0] LAST_PAY = 3'(PRE_LEN + PAY_LEN - 1);

    state_t     state, next_state;
    logic [2:0] bit_idx, next_idx;
    logic [3:0] cap, next_cap;
    logic       next_data;
    logic       next_timeout;
    logic       cnt_clear;
    logic       cnt_en;
    logic       expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= '0;
            cap     <= '0;
            data    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= next_state;
            bit_idx <= next_idx;
            cap     <= next_cap;
            data    <= next_data;
            timeout <= next_timeout;
        end
    end

    // data is registered, so each branch computes the bit for the state being entered.
    always_comb begin
        next_state   = state;
        next_idx     = bit_idx;
        next_cap     = cap;
        next_data    = 1'b0;
        next_timeout = 1'b0;
        cnt_clear    = 1'b1;
        cnt_en       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    next_state = PRE;
                    next_idx   = '0;
                    next_cap   = delay;
                    next_data  = frame_bit(3'd0, delay);
                end
            end
            PRE: begin
                next_idx  = bit_idx + 3'd1;
                next_data = frame_bit(next_idx, cap);
                if (bit_idx == LAST_PRE) begin
                    next_state = PAY;
                end
            end
            PAY: begin
                if (bit_idx == LAST_PAY) begin
                    next_state = WAIT_DONE;
                    next_idx   = '0;
                end else begin
                    next_idx  = bit_idx + 3'd1;
                    next_data = frame_bit(next_idx, cap);
                end
            end
            WAIT_DONE: begin
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                // done is checked first so it wins over a coincident expiry.
                if (done) begin
                    next_state = ACK;
                end else if (expired) begin
                    next_state   = IDLE;
                    next_timeout = 1'b1;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign ack  = (state == ACK);

    seq_cmd_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .clear  (cnt_clear | reset),
        .enable (cnt_en),
        .expired(expired)
    );

endmodule
